serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be >=1 (elaboration error otherwise).
REQ-002 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 Port rst, input, 1, synchronous active-high reset.
REQ-004 Port in_valid, input, 1, operands a/b/cin presented.
REQ-005 Port in_ready, output, 1, controller accepts operands (IDLE only).
REQ-006 Port a, input, WIDTH, operand A.
REQ-007 Port b, input, WIDTH, operand B.
REQ-008 Port cin, input, 1, carry-in.
REQ-009 Port out_valid, output, 1, result available.
REQ-010 Port out_ready, input, 1, consumer takes result.
REQ-011 Port sum, output, WIDTH, registered result.
REQ-012 Port cout, output, 1, registered carry-out.
REQ-013 Port busy, output, 1, high whenever state != IDLE.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready edge SHALL load a/b into shift registers, carry reg <= cin, bit counter <= 0, go RUN.
REQ-016 RUN: each cycle SHALL feed a_sh[0], b_sh[0], carry reg to the single one-bit full adder; sum bit shifted into sum_sh MSB (shift right); carry reg <= adder cout; a_sh/b_sh shift right; counter +1.
REQ-017 RUN SHALL last exactly WIDTH cycles; on counter==WIDTH-1 edge SHALL copy final sum_sh into sum, carry into cout, go DONE.
REQ-018 Latency: out_valid SHALL rise exactly WIDTH edges after the accepting edge.
REQ-019 DONE: out_valid=1; on out_ready edge SHALL go IDLE; out_valid deasserts next cycle.
REQ-020 No back-to-back acceptance in DONE; in_ready=0 in RUN and DONE; in_valid ignored outside IDLE.
REQ-021 a, b, cin changes after acceptance SHALL have no effect on the in-flight result.
REQ-022 sum/cout SHALL hold the last completed result unchanged through DONE, IDLE and the next RUN, until the next RUN->DONE edge.
REQ-023 Result SHALL equal (a+b+cin) mod 2^WIDTH, cout = bit WIDTH of that sum.
REQ-024 Counter width SHALL be max(1, clog2(WIDTH)); no wrap occurs for WIDTH=1 (RUN lasts one cycle).

Reset
REQ-025 rst SHALL force IDLE from any state on the next edge, aborting any in-flight operation.
REQ-026 Reset values: in_ready=1 after reset, out_valid=0, busy=0, sum=0, cout=0, shift regs/carry/counter=0.
REQ-027 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-028 Shared package SHALL hold FSM state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
REQ-029 Exactly one sub-module SHALL be instantiated: add_1, the existing one-bit full adder, as the sole arithmetic element.
REQ-030 No other adder or '+' operator on operand data SHALL appear in the block.

Verification
REQ-031 WIDTH=8, a=8'h5A, b=8'h3C, cin=0, out_ready=1 -> sum=8'h96, cout=0, out_valid exactly 8 edges after acceptance.
REQ-032 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 (full carry ripple).
REQ-033 a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-034 out_ready held 0 for 5 cycles in DONE, in_valid=1 with new operands -> out_valid, sum, cout stable, in_ready=0, new operands ignored; IDLE one edge after out_ready=1.
REQ-035 rst pulsed during RUN at bit 3 -> next cycle IDLE, in_ready=1, out_valid=0, busy=0, sum=0; following a=8'h01, b=8'h02 -> sum=8'h03.
REQ-036 WIDTH=1, a=1, b=1, cin=1 -> sum=1, cout=1, out_valid 1 edge after acceptance.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and
// counter sizing helper.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A one-bit result still needs a one-bit counter.
  function automatic int cnt_w(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_add_1.sv
// One-bit full adder; the only arithmetic element of the serial datapath.
module add_1 (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: accepts a/b/cin, adds one bit per cycle
// through a single full adder, and presents a registered sum/cout.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("serial_add_ctrl: WIDTH must be >= 1");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;

  add_1 u_add_1 (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_nxt = fa_s;
    end else begin : g_wn
      assign sum_nxt = {fa_s, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= cin;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_nxt;
          carry  <= fa_co;
          if (cnt == LAST) begin
            sum       <= sum_nxt;
            cout      <= fa_co;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready, cin;
  logic       in_ready, out_valid, cout, busy;
  logic [7:0] a, b, sum;

  logic       w1_in_valid, w1_out_ready, w1_cin;
  logic       w1_in_ready, w1_out_valid, w1_cout, w1_busy;
  logic [0:0] w1_a, w1_b, w1_sum;

  int tests = 0;
  int fails = 0;
  logic [7:0] prev_sum;
  logic       prev_cout;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_add_ctrl #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst(rst), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
    .a(w1_a), .b(w1_b), .cin(w1_cin), .out_valid(w1_out_valid),
    .out_ready(w1_out_ready), .sum(w1_sum), .cout(w1_cout), .busy(w1_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, scramble inputs while it runs, check latency and result.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input string name);
    logic [8:0] exp;
    int lat;
    exp = {1'b0, ta} + {1'b0, tb_} + {8'd0, tc};
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
    end
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    tests++;
    if (sum !== prev_sum || cout !== prev_cout || busy !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s hold during run: sum=%h cout=%b busy=%b in_ready=%b want sum=%h cout=%b busy=1 in_ready=0",
               name, sum, cout, busy, in_ready, prev_sum, prev_cout);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (lat == 2) begin a = ~a; b = ~b; cin = ~cin; end
      step();
      lat++;
    end
    tests++;
    if (lat != 8) begin
      fails++; $display("FAIL %s latency: got %0d want 8", name, lat);
    end
    tests++;
    if ({cout, sum} !== exp) begin
      fails++; $display("FAIL %s result: got %b_%h want %b_%h", name, cout, sum, exp[8], exp[7:0]);
    end
    prev_sum = exp[7:0]; prev_cout = exp[8];
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
        sum !== prev_sum || cout !== prev_cout) begin
      fails++;
      $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b sum=%h cout=%b want 0 1 0 %h %b",
               name, out_valid, in_ready, busy, sum, cout, prev_sum, prev_cout);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0;
    w1_in_valid = 0; w1_out_ready = 0; w1_a = 0; w1_b = 0; w1_cin = 0;
    step(); step();
    rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      fails++;
      $display("FAIL reset w8: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b want 1 0 0 00 0",
               in_ready, out_valid, busy, sum, cout);
    end
    tests++;
    if (w1_in_ready !== 1'b1 || w1_out_valid !== 1'b0 || w1_busy !== 1'b0 ||
        w1_sum !== 1'b0 || w1_cout !== 1'b0) begin
      fails++;
      $display("FAIL reset w1: in_ready=%b out_valid=%b busy=%b sum=%b cout=%b want 1 0 0 0 0",
               w1_in_ready, w1_out_valid, w1_busy, w1_sum, w1_cout);
    end
    prev_sum = 8'h00; prev_cout = 1'b0;
  endtask

  task automatic test_directed();
    run_op(8'h5A, 8'h3C, 1'b0, "5a_3c");
    release_result("5a_3c");
    run_op(8'hFF, 8'h01, 1'b0, "ff_01");
    release_result("ff_01");
    run_op(8'hFF, 8'hFF, 1'b1, "ff_ff_1");
    release_result("ff_ff_1");
    run_op(8'h00, 8'h00, 1'b0, "zero");
    release_result("zero");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), "random");
      for (int d = $urandom_range(0, 3); d > 0; d--) step();
      release_result("random");
    end
  endtask

  task automatic test_backpressure();
    run_op(8'h12, 8'h34, 1'b1, "bp");
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      step();
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
          sum !== 8'h47 || cout !== 1'b0) begin
        fails++;
        $display("FAIL bp stall: out_valid=%b in_ready=%b busy=%b sum=%h cout=%b want 1 0 1 47 0",
                 out_valid, in_ready, busy, sum, cout);
      end
    end
    in_valid = 1'b0;
    release_result("bp");
  endtask

  task automatic test_reset_mid_run();
    a = 8'hAB; b = 8'hCD; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      fails++;
      $display("FAIL abort: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b want 1 0 0 00 0",
               in_ready, out_valid, busy, sum, cout);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL abort stays idle: out_valid=%b busy=%b want 0 0", out_valid, busy);
      end
    end
    prev_sum = 8'h00; prev_cout = 1'b0;
    run_op(8'h01, 8'h02, 1'b0, "after_abort");
    release_result("after_abort");
  endtask

  task automatic test_width1();
    for (int i = 0; i < 8; i++) begin
      logic [1:0] exp;
      int lat;
      w1_a = 1'(i >> 2); w1_b = 1'(i >> 1); w1_cin = 1'(i);
      if (i == 0) begin w1_a = 1'b1; w1_b = 1'b1; w1_cin = 1'b1; end
      exp = {1'b0, w1_a} + {1'b0, w1_b} + {1'b0, w1_cin};
      w1_in_valid = 1'b1;
      step();
      w1_in_valid = 1'b0;
      w1_a = ~w1_a; w1_b = ~w1_b; w1_cin = ~w1_cin;
      lat = 0;
      while (!w1_out_valid && lat < 10) begin step(); lat++; end
      tests++;
      if (lat != 1 || {w1_cout, w1_sum} !== exp) begin
        fails++;
        $display("FAIL w1 op%0d: lat=%0d cout=%b sum=%b want lat=1 %b %b",
                 i, lat, w1_cout, w1_sum, exp[1], exp[0]);
      end
      w1_out_ready = 1'b1;
      step();
      w1_out_ready = 1'b0;
      tests++;
      if (w1_in_ready !== 1'b1 || w1_out_valid !== 1'b0 || w1_busy !== 1'b0) begin
        fails++;
        $display("FAIL w1 release: in_ready=%b out_valid=%b busy=%b want 1 0 0",
                 w1_in_ready, w1_out_valid, w1_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
